uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART transmitter among NREQ byte-stream requesters. Each requester presents packets, one byte at a time, with a LAST marker. A packet, once granted, owns the UART until its LAST byte is accepted. The block sits between the requesters and the UART's DIN/OE/RDY port, and sequences the one-cycle OE strobe against RDY.

---
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ packet requesters.
// Optional stall timeout is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NREQ-1:0]   REQ_VALID,
   input  logic [8*NREQ-1:0] REQ_DATA,
   input  logic [NREQ-1:0]   REQ_LAST,
   output logic [NREQ-1:0]   REQ_READY,
   output logic [NREQ-1:0]   GRANT,
   output logic [7:0]        UART_DIN,
   output logic              UART_OE,
   input  logic              UART_RDY,
   output logic              ABORT
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_ISSUE, S_DRAIN} state_t;

   state_t          state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [IW-1:0]   gidx_q, gidx_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [7:0]      din_q, din_d;
   logic            oe_q, oe_d;
   logic            last_q, last_d;
   logic            abort_q, abort_d;

   logic            xfer;
   logic            stall_expired;
   logic [IW-1:0]   ptr_nxt;
   logic [IW-1:0]   pick;
   logic            pick_vld;
   logic [IW:0]     cand;

   // First valid requester at or above the pointer, wrapping modulo NREQ.
   always_comb begin
      pick     = ptr_q;
      pick_vld = 1'b0;
      cand     = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr_q} + (IW+1)'(k);
         if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
         if (!pick_vld && REQ_VALID[cand[IW-1:0]]) begin
            pick     = cand[IW-1:0];
            pick_vld = 1'b1;
         end
      end
   end

   assign ptr_nxt   = (gidx_q == IW'(NREQ-1)) ? '0 : gidx_q + 1'b1;
   assign REQ_READY = (state_q == S_SEND && UART_RDY) ? grant_q : '0;
   assign xfer      = (state_q == S_SEND) && UART_RDY && REQ_VALID[gidx_q];

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;

   // Counts consecutive SEND cycles in which the owner has nothing to offer.
   always_comb begin
      cnt_d = '0;
      if (state_q == S_SEND && !REQ_VALID[gidx_q]) cnt_d = cnt_q + 1'b1;
   end

   assign stall_expired = (state_q == S_SEND) && !REQ_VALID[gidx_q] &&
                          (cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`else
   assign stall_expired = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      ptr_d   = ptr_q;
      din_d   = din_q;
      oe_d    = 1'b0;
      last_d  = last_q;
      abort_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               gidx_d  = pick;
               grant_d = NREQ'(1) << pick;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (xfer) begin
               din_d   = REQ_DATA[{gidx_q, 3'b000} +: 8];
               last_d  = REQ_LAST[gidx_q];
               oe_d    = 1'b1;
               state_d = S_ISSUE;
            end else if (stall_expired) begin
               abort_d = 1'b1;
               grant_d = '0;
               ptr_d   = ptr_nxt;
               state_d = S_IDLE;
            end
         end
         S_ISSUE: state_d = S_DRAIN;
         S_DRAIN: begin
            // The UART drops RDY the cycle after it latches the byte.
            if (!UART_RDY) begin
               if (last_q) begin
                  grant_d = '0;
                  ptr_d   = ptr_nxt;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_SEND;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         ptr_q   <= '0;
         din_q   <= '0;
         oe_q    <= 1'b0;
         last_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
         din_q   <= din_d;
         oe_q    <= oe_d;
         last_q  <= last_d;
         abort_q <= abort_d;
      end
   end

   assign GRANT    = grant_q;
   assign UART_DIN = din_q;
   assign UART_OE  = oe_q;
   assign ABORT    = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: four byte-queue requesters and a UART
// model that holds RDY low for 10 cycles after each accepted strobe.
module tb_uart_tx_arbiter;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [3:0]  REQ_VALID;
   logic [31:0] REQ_DATA;
   logic [3:0]  REQ_LAST;
   logic [3:0]  REQ_READY;
   logic [3:0]  GRANT;
   logic [7:0]  UART_DIN;
   logic        UART_OE;
   logic        UART_RDY;
   logic        ABORT;

   int tests = 0;
   int fails = 0;

   uart_tx_arbiter #(.NREQ(4), .TIMEOUT(16)) dut (
      .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
      .REQ_LAST(REQ_LAST), .REQ_READY(REQ_READY), .GRANT(GRANT),
      .UART_DIN(UART_DIN), .UART_OE(UART_OE), .UART_RDY(UART_RDY), .ABORT(ABORT)
   );

   always #5 CLK = ~CLK;

   // Requester byte queues: {last, data}
   logic [8:0] mem [4][32];
   logic [4:0] head [4];
   logic [4:0] tail [4];

   for (genvar i = 0; i < 4; i++) begin : g_req
      assign REQ_VALID[i]       = (head[i] != tail[i]);
      assign REQ_DATA[8*i +: 8] = mem[i][head[i]][7:0];
      assign REQ_LAST[i]        = mem[i][head[i]][8];
   end

   always @(posedge CLK) begin
      for (int i = 0; i < 4; i++) begin
         if (RST) head[i] <= tail[i];
         else if (REQ_VALID[i] && REQ_READY[i]) head[i] <= head[i] + 5'd1;
      end
   end

   // UART model and capture log
   logic [3:0] busy;
   logic       hold_low = 1'b0;
   assign UART_RDY = (busy == 4'd0) && !hold_low;

   always @(posedge CLK or posedge RST) begin
      if (RST) busy <= 4'd0;
      else if (UART_OE && UART_RDY) busy <= 4'd10;
      else if (busy != 4'd0) busy <= busy - 4'd1;
   end

   logic [7:0] cap_data [64];
   logic [3:0] cap_gnt  [64];
   int         ncap = 0;
   int         oe_double = 0;
   int         oe_nordy = 0;
   logic       oe_prev = 1'b0;

   always @(posedge CLK) begin
      oe_prev <= UART_OE;
      if (UART_OE && oe_prev) oe_double <= oe_double + 1;
      if (UART_OE && !UART_RDY) oe_nordy <= oe_nordy + 1;
      if (!RST && UART_OE && UART_RDY) begin
         cap_data[ncap] <= UART_DIN;
         cap_gnt[ncap]  <= GRANT;
         ncap           <= ncap + 1;
      end
   end

   task automatic push(input logic [1:0] r, input logic [7:0] d, input logic l);
      mem[r][tail[r]] = {l, d};
      tail[r] = tail[r] + 5'd1;
   endtask

   function automatic bit q_empty();
      bit e = 1'b1;
      for (int i = 0; i < 4; i++) if (head[i] != tail[i]) e = 1'b0;
      return e;
   endfunction

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge CLK);
         if (GRANT == 4'd0 && !UART_OE && busy == 4'd0 && q_empty()) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic pulse_reset();
      @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_reset();
      bit ok;
      int base;
      @(negedge CLK);
      tests++; if (GRANT !== 4'd0 || UART_OE !== 1'b0 || UART_DIN !== 8'h00 || REQ_READY !== 4'd0 || ABORT !== 1'b0) begin
         fails++; $display("FAIL reset_state: grant=%b oe=%b din=%h ready=%b abort=%b, required all zero", GRANT, UART_OE, UART_DIN, REQ_READY, ABORT);
      end
      RST = 1'b0;
      base = ncap;
      push(2'd1, 8'h11, 1'b1);
      wait_idle(100, ok);
      tests++; if (!ok) begin fails++; $display("FAIL reset_warmup_idle: timed out, required idle"); end
      // pointer is now 2; all of 0,2,3 request
      push(2'd0, 8'h20, 1'b1); push(2'd2, 8'h22, 1'b1); push(2'd3, 8'h23, 1'b1);
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin @(negedge CLK); ok = UART_OE; end
      tests++; if (!ok || GRANT !== 4'b0100 || UART_DIN !== 8'h22) begin
         fails++; $display("FAIL reset_pre_issue: oe_seen=%0d grant=%b din=%h, required 1 0100 22", ok, GRANT, UART_DIN);
      end
      RST = 1'b1;
      #1;
      tests++; if (GRANT !== 4'd0 || UART_OE !== 1'b0 || UART_DIN !== 8'h00 || REQ_READY !== 4'd0 || ABORT !== 1'b0) begin
         fails++; $display("FAIL reset_async: grant=%b oe=%b din=%h ready=%b abort=%b, required all zero", GRANT, UART_OE, UART_DIN, REQ_READY, ABORT);
      end
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      push(2'd2, 8'h32, 1'b1); push(2'd0, 8'h30, 1'b1);
      @(negedge CLK);
      tests++; if (GRANT !== 4'b0001) begin fails++; $display("FAIL reset_first_grant: got %b, required 0001", GRANT); end
      wait_idle(200, ok);
      tests++; if (!ok || ncap - base != 3 || cap_data[base+1] !== 8'h30 || cap_data[base+2] !== 8'h32) begin
         fails++; $display("FAIL reset_after_bytes: count=%0d b1=%h b2=%h, required 3 30 32", ncap - base, cap_data[base+1], cap_data[base+2]);
      end
   endtask

   task automatic test_single_packet();
      bit ok;
      int base, bad, rbad;
      logic [7:0] exp_d [3];
      exp_d[0] = 8'h41; exp_d[1] = 8'h42; exp_d[2] = 8'h43;
      base = ncap; bad = 0; rbad = 0;
      push(2'd1, 8'h41, 1'b0); push(2'd1, 8'h42, 1'b0); push(2'd1, 8'h43, 1'b1);
      @(negedge CLK);
      tests++; if (GRANT !== 4'b0010 || REQ_READY !== 4'b0010) begin
         fails++; $display("FAIL single_cycle1: grant=%b ready=%b, required 0010 0010", GRANT, REQ_READY);
      end
      @(negedge CLK);
      tests++; if (UART_OE !== 1'b1 || UART_DIN !== 8'h41) begin
         fails++; $display("FAIL single_cycle2: oe=%b din=%h, required 1 41", UART_OE, UART_DIN);
      end
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge CLK);
         if (REQ_READY != 4'd0 && !UART_RDY) rbad++;
         if (GRANT == 4'd0) begin ok = 1'b1; break; end
         if (GRANT != 4'b0010) bad++;
      end
      tests++; if (!ok || bad != 0 || rbad != 0) begin
         fails++; $display("FAIL single_grant_hold: released=%0d bad=%0d ready_wo_rdy=%0d, required 1 0 0", ok, bad, rbad);
      end
      tests++; if (ncap - base != 3) begin fails++; $display("FAIL single_count: got %0d, required 3", ncap - base); end
      for (int k = 0; k < 3; k++) begin
         tests++; if (cap_data[base+k] !== exp_d[k] || cap_gnt[base+k] !== 4'b0010) begin
            fails++; $display("FAIL single_byte%0d: data=%h grant=%b, required %h 0010", k, cap_data[base+k], cap_gnt[base+k], exp_d[k]);
         end
      end
      wait_idle(50, ok);
   endtask

   task automatic test_fairness();
      bit ok, started;
      int base, zrun, gaps, gap_bad;
      logic [3:0] prevg;
      pulse_reset();
      base = ncap; zrun = 0; gaps = 0; gap_bad = 0; started = 1'b0; prevg = 4'd0; ok = 1'b0;
      push(2'd3, 8'hA3, 1'b1); push(2'd2, 8'hA2, 1'b1); push(2'd1, 8'hA1, 1'b1); push(2'd0, 8'hA0, 1'b1);
      for (int c = 0; c < 300; c++) begin
         @(negedge CLK);
         if (GRANT == 4'd0) zrun++;
         else begin
            if (prevg == 4'd0 && started) begin gaps++; if (zrun != 1) gap_bad++; end
            started = 1'b1; zrun = 0;
         end
         prevg = GRANT;
         if (ncap - base == 4 && GRANT == 4'd0) begin ok = 1'b1; break; end
      end
      tests++; if (!ok || gaps != 3 || gap_bad != 0) begin
         fails++; $display("FAIL fair_gaps: done=%0d gaps=%0d bad=%0d, required 1 3 0", ok, gaps, gap_bad);
      end
      for (int k = 0; k < 4; k++) begin
         tests++; if (cap_gnt[base+k] !== (4'b0001 << k)) begin
            fails++; $display("FAIL fair_order%0d: got %b, required %b", k, cap_gnt[base+k], 4'b0001 << k);
         end
      end
      wait_idle(50, ok);
      base = ncap;
      push(2'd2, 8'hB2, 1'b1); push(2'd0, 8'hB0, 1'b1);
      wait_idle(200, ok);
      tests++; if (!ok || ncap - base != 2 || cap_gnt[base] !== 4'b0001 || cap_gnt[base+1] !== 4'b0100) begin
         fails++; $display("FAIL fair_reorder: count=%0d g0=%b g1=%b, required 2 0001 0100", ncap - base, cap_gnt[base], cap_gnt[base+1]);
      end
   endtask

   task automatic test_packet_lock();
      bit ok;
      int base;
      logic [7:0] exp_d [5];
      logic [3:0] exp_g [5];
      exp_d[0] = 8'hC0; exp_d[1] = 8'hC1; exp_d[2] = 8'hC2; exp_d[3] = 8'hD0; exp_d[4] = 8'hD1;
      exp_g[0] = 4'b0001; exp_g[1] = 4'b0001; exp_g[2] = 4'b0001; exp_g[3] = 4'b0010; exp_g[4] = 4'b0010;
      base = ncap;
      push(2'd1, 8'hD0, 1'b0); push(2'd1, 8'hD1, 1'b1);
      push(2'd0, 8'hC0, 1'b0); push(2'd0, 8'hC1, 1'b0); push(2'd0, 8'hC2, 1'b1);
      wait_idle(300, ok);
      tests++; if (!ok || ncap - base != 5) begin fails++; $display("FAIL lock_count: done=%0d count=%0d, required 1 5", ok, ncap - base); end
      for (int k = 0; k < 5; k++) begin
         tests++; if (cap_data[base+k] !== exp_d[k] || cap_gnt[base+k] !== exp_g[k]) begin
            fails++; $display("FAIL lock_byte%0d: data=%h grant=%b, required %h %b", k, cap_data[base+k], cap_gnt[base+k], exp_d[k], exp_g[k]);
         end
      end
   endtask

   task automatic test_handshake();
      bit ok;
      int bad;
      hold_low = 1'b1;
      bad = 0;
      push(2'd3, 8'h5A, 1'b1);
      @(negedge CLK);
      tests++; if (GRANT !== 4'b1000) begin fails++; $display("FAIL hs_grant: got %b, required 1000", GRANT); end
      for (int c = 0; c < 20; c++) begin
         @(negedge CLK);
         if (REQ_READY != 4'd0 || UART_OE) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL hs_blocked: %0d cycles with ready/oe, required 0", bad); end
      hold_low = 1'b0;
      #1;
      tests++; if (REQ_READY !== 4'b1000) begin fails++; $display("FAIL hs_ready: got %b, required 1000", REQ_READY); end
      @(negedge CLK);
      tests++; if (UART_OE !== 1'b1 || UART_DIN !== 8'h5A) begin
         fails++; $display("FAIL hs_strobe: oe=%b din=%h, required 1 5a", UART_OE, UART_DIN);
      end
      @(negedge CLK);
      tests++; if (UART_OE !== 1'b0 || UART_DIN !== 8'h5A) begin
         fails++; $display("FAIL hs_strobe_end: oe=%b din=%h, required 0 5a", UART_OE, UART_DIN);
      end
      wait_idle(100, ok);
   endtask

   task automatic test_timeout();
      bit ok;
      int base, bad;
      base = ncap; bad = 0; ok = 1'b0;
      push(2'd2, 8'h77, 1'b0); push(2'd3, 8'h88, 1'b1);
      for (int c = 0; c < 10 && !ok; c++) begin @(negedge CLK); ok = UART_OE; end
      tests++; if (!ok || GRANT !== 4'b0100 || UART_DIN !== 8'h77) begin
         fails++; $display("FAIL to_first: oe_seen=%0d grant=%b din=%h, required 1 0100 77", ok, GRANT, UART_DIN);
      end
`ifdef UART_ARB_TIMEOUT_EN
      for (int k = 1; k <= 17; k++) begin
         @(negedge CLK);
         if (ABORT || GRANT != 4'b0100) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL to_early: %0d early cycles, required 0", bad); end
      @(negedge CLK);
      tests++; if (ABORT !== 1'b1 || GRANT !== 4'b0000) begin
         fails++; $display("FAIL to_abort: abort=%b grant=%b, required 1 0000", ABORT, GRANT);
      end
      @(negedge CLK);
      tests++; if (ABORT !== 1'b0 || GRANT !== 4'b1000) begin
         fails++; $display("FAIL to_next: abort=%b grant=%b, required 0 1000", ABORT, GRANT);
      end
      wait_idle(100, ok);
      tests++; if (!ok || ncap - base != 2 || cap_data[base+1] !== 8'h88 || cap_gnt[base+1] !== 4'b1000) begin
         fails++; $display("FAIL to_after: count=%0d data=%h grant=%b, required 2 88 1000", ncap - base, cap_data[base+1], cap_gnt[base+1]);
      end
`else
      for (int k = 0; k < 1000; k++) begin
         @(negedge CLK);
         if (ABORT || GRANT != 4'b0100) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL to_hold: %0d cycles off 0100 or abort, required 0", bad); end
      push(2'd2, 8'h79, 1'b1);
      wait_idle(100, ok);
      tests++; if (!ok || ncap - base != 3 || cap_data[base+1] !== 8'h79 || cap_gnt[base+1] !== 4'b0100
                  || cap_data[base+2] !== 8'h88 || cap_gnt[base+2] !== 4'b1000) begin
         fails++; $display("FAIL to_resume: count=%0d b1=%h/%b b2=%h/%b, required 3 79/0100 88/1000",
                           ncap - base, cap_data[base+1], cap_gnt[base+1], cap_data[base+2], cap_gnt[base+2]);
      end
`endif
   endtask

   task automatic test_oe_strobe();
      tests++; if (oe_double != 0 || oe_nordy != 0) begin
         fails++; $display("FAIL oe_strobe: double=%0d without_rdy=%0d, required 0 0", oe_double, oe_nordy);
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) tail[i] = 5'd0;
      #1 RST = 1'b1;
      test_reset();
      test_single_packet();
      test_fairness();
      test_packet_lock();
      test_handshake();
      test_timeout();
      test_oe_strobe();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
